traffic_ctrl_gen: RTL and testbench

//  Parametrised two-road intersection controller: internal 1 s tick prescaler, 6-state phase FSM

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/bcd_dn_cnt.sv | 29 ++
 rtl/traffic_ctrl_gen.sv | 153 +++++++++++++++
 tb/tb_traffic_ctrl_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road intersection controller.
// Phase encoding, lamp patterns and a constant-friendly BCD conversion helper.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR1  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR2  = 3'd5
   } state_t;

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   // Two-digit BCD {tens,units}; valid for 0..99.
   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_dn_cnt.sv
// Two-digit BCD down counter with synchronous load; load has priority over decrement.
// Decrement borrows digit-wise (x0 -> (x-1)9) without a binary intermediate.
module bcd_dn_cnt #(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic [7:0] out,
   output logic       is_one
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= RST_VAL;
      end else if (load) begin
         out <= load_val;
      end else if (dec) begin
         if (out[3:0] == 4'd0) out <= {out[7:4] - 4'd1, 4'd9};
         else                  out <= {out[7:4], out[3:0] - 4'd1};
      end
   end

   assign is_one = (out == 8'h01);

endmodule

// File: rtl/traffic_ctrl_gen.sv
// Two-road intersection controller: tick prescaler, six-phase FSM with all-red clearance,
// pedestrian green truncation, freeze enable and a BCD countdown of the current phase.
module traffic_ctrl_gen
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int GREEN_T  = 30,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int PED_MIN  = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic       ped_pend,
   output logic [7:0] cnt_bcd,
   output logic       tick
);

   if (TICK_DIV < 2) begin : g_bad_div
      $error("traffic_ctrl_gen: TICK_DIV must be >= 2");
   end
   if (GREEN_T < 1 || GREEN_T > 99 || YELLOW_T < 1 || YELLOW_T > 99 ||
       ALLRED_T < 1 || ALLRED_T > 99) begin : g_bad_dur
      $error("traffic_ctrl_gen: phase durations must be 1..99");
   end
   if (PED_MIN < 1 || PED_MIN > GREEN_T) begin : g_bad_ped
      $error("traffic_ctrl_gen: PED_MIN must be 1..GREEN_T");
   end

   localparam int         PSC_W      = $clog2(TICK_DIV);
   localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_T);
   localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_T);
   localparam logic [7:0] ALLRED_BCD = to_bcd(ALLRED_T);
   localparam logic [7:0] PED_BCD    = to_bcd(PED_MIN);

   logic [PSC_W-1:0] psc;
   logic             tick_now;
   state_t           state_q, state_d;
   logic             cnt_load, cnt_dec, cnt_is_one, pend_clr;
   logic [7:0]       cnt_load_val;

   function automatic state_t next_of(input state_t s);
      case (s)
         NS_G:    return NS_Y;
         NS_Y:    return AR1;
         AR1:     return EW_G;
         EW_G:    return EW_Y;
         EW_Y:    return AR2;
         default: return NS_G;
      endcase
   endfunction

   function automatic logic [7:0] dur_of(input state_t s);
      case (s)
         NS_G, EW_G: return GREEN_BCD;
         NS_Y, EW_Y: return YELLOW_BCD;
         default:    return ALLRED_BCD;
      endcase
   endfunction

   function automatic logic [2:0] ns_of(input state_t s);
      case (s)
         NS_G:    return L_GRN;
         NS_Y:    return L_YEL;
         default: return L_RED;
      endcase
   endfunction

   function automatic logic [2:0] ew_of(input state_t s);
      case (s)
         EW_G:    return L_GRN;
         EW_Y:    return L_YEL;
         default: return L_RED;
      endcase
   endfunction

   assign tick_now = en && (psc == PSC_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)     psc <= '0;
      else if (en) psc <= tick_now ? '0 : psc + 1'b1;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = GREEN_BCD;
      cnt_dec      = 1'b0;
      case (state_q)
         NS_G, NS_Y, AR1, EW_G, EW_Y, AR2: begin
            if (tick_now) begin
               if (cnt_is_one) begin
                  state_d      = next_of(state_q);
                  cnt_load     = 1'b1;
                  cnt_load_val = dur_of(state_d);
               end else if ((state_q == NS_G || state_q == EW_G) && ped_pend &&
                            (cnt_bcd > PED_BCD)) begin
                  // BCD preserves numeric order, so the compare works on the digits directly.
                  cnt_load     = 1'b1;
                  cnt_load_val = PED_BCD;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         default: begin
            state_d  = NS_G;
            cnt_load = 1'b1;
         end
      endcase
   end

   assign pend_clr = (state_d != state_q) && (state_d == AR1 || state_d == AR2);

   // Lamps and walk are decoded from the next state so they switch on the tick edge itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= NS_G;
         ped_pend <= 1'b0;
         tick     <= 1'b0;
         ns_light <= L_GRN;
         ew_light <= L_RED;
         walk     <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick     <= tick_now;
         ns_light <= ns_of(state_d);
         ew_light <= ew_of(state_d);
         walk     <= (state_d == AR1) || (state_d == AR2);
         if (ped_req)       ped_pend <= 1'b1;
         else if (pend_clr) ped_pend <= 1'b0;
      end
   end

   bcd_dn_cnt #(
      .RST_VAL(GREEN_BCD)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (cnt_load),
      .load_val(cnt_load_val),
      .dec     (cnt_dec),
      .out     (cnt_bcd),
      .is_one  (cnt_is_one)
   );

endmodule

// File: tb/tb_traffic_ctrl_gen.sv
// Bench for traffic_ctrl_gen: directed phase/pedestrian/freeze/reset steps plus random en/ped_req,
// every cycle compared with a tick-level model of the phase sequence.
module tb_traffic_ctrl_gen;

   localparam int DIV  = 4;
   localparam int GRN  = 6;
   localparam int YEL  = 2;
   localparam int ALR  = 1;
   localparam int PMIN = 2;
   localparam int DUR [6] = '{GRN, YEL, ALR, GRN, YEL, ALR};
   localparam logic [2:0] NS_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   localparam logic [2:0] EW_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

   logic       clk = 1'b0;
   logic       rst, en, ped_req;
   logic [2:0] ns_light, ew_light, ns12, ew12;
   logic       walk, ped_pend, tick, walk12, pend12, tick12;
   logic [7:0] cnt_bcd, cnt12;

   int n_checks = 0;
   int n_errors = 0;

   int m_phase, m_rem, m_psc;
   bit m_pend, m_tick;

   always #5 clk = ~clk;

   traffic_ctrl_gen #(
      .TICK_DIV(DIV), .GREEN_T(GRN), .YELLOW_T(YEL), .ALLRED_T(ALR), .PED_MIN(PMIN)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
      .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
      .ped_pend(ped_pend), .cnt_bcd(cnt_bcd), .tick(tick)
   );

   traffic_ctrl_gen #(
      .TICK_DIV(DIV), .GREEN_T(12), .YELLOW_T(YEL), .ALLRED_T(ALR), .PED_MIN(PMIN)
   ) dut12 (
      .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
      .ns_light(ns12), .ew_light(ew12), .walk(walk12),
      .ped_pend(pend12), .cnt_bcd(cnt12), .tick(tick12)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   // Tick-level reference: phase index, ticks remaining, prescaler count, pending flag.
   function automatic void model_step(input bit r, input bit e, input bit p);
      bit t;
      if (r) begin
         m_phase = 0; m_rem = GRN; m_psc = 0; m_pend = 1'b0; m_tick = 1'b0;
      end else begin
         t = e && (m_psc == DIV - 1);
         if (e) m_psc = (m_psc + 1) % DIV;
         m_tick = t;
         if (t) begin
            if (m_rem == 1) begin
               m_phase = (m_phase + 1) % 6;
               m_rem   = DUR[m_phase];
               if (m_phase == 2 || m_phase == 5) m_pend = 1'b0;
            end else if ((m_phase == 0 || m_phase == 3) && m_pend && m_rem > PMIN) begin
               m_rem = PMIN;
            end else begin
               m_rem = m_rem - 1;
            end
         end
         if (p) m_pend = 1'b1;
      end
   endfunction

   task automatic compare_all();
      check("ns_light", ns_light, NS_TAB[m_phase]);
      check("ew_light", ew_light, EW_TAB[m_phase]);
      check("walk", walk, (m_phase == 2 || m_phase == 5));
      check("ped_pend", ped_pend, m_pend);
      check("cnt_bcd", cnt_bcd, 32'((m_rem / 10) * 16 + (m_rem % 10)));
      check("tick", tick, m_tick);
      check("tick12", tick12, m_tick);
      check("excl", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
      check("excl12", (ns12 != 3'b100) && (ew12 != 3'b100), 0);
   endtask

   task automatic cyc(input bit r, input bit e, input bit p);
      rst = r; en = e; ped_req = p;
      @(posedge clk);
      model_step(r, e, p);
      #1;
      compare_all();
   endtask

   task automatic run_until(input int ph, input int rem, input string tag);
      int n = 0;
      while (!(m_tick && m_phase == ph && m_rem == rem) && n < 400) begin
         cyc(1'b0, 1'b1, 1'b0);
         n++;
      end
      check({tag, "_reach"}, (n < 400), 1);
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      do begin
         cyc(1'b0, 1'b1, 1'b0);
         n++;
      end while (!tick && n < 8);
      check({tag, "_tick"}, tick, 1);
   endtask

   initial begin
      int nt;
      int n;
      rst = 1'b1; en = 1'b1; ped_req = 1'b0;

      // Reset state for both builds.
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      check("rst_cnt", cnt_bcd, 8'h06);
      check("rst_ns", ns_light, 3'b001);
      check("rst_ew", ew_light, 3'b100);
      check("rst_cnt12", cnt12, 8'h12);
      check("rst_walk12", walk12, 0);
      check("rst_pend12", pend12, 0);

      // Free run: tick every 4th clock, BCD borrow on the 12-tick build.
      nt = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (tick) begin
            nt++;
            if (nt == 2) check("g12_10", cnt12, 8'h10);
            if (nt == 3) check("g12_09", cnt12, 8'h09);
         end
      end
      check("tick_count", nt, 10);

      // Pedestrian truncation in NS green.
      run_until(0, 5, "t2");
      cyc(1'b0, 1'b1, 1'b1);
      check("t2_pend_set", ped_pend, 1);
      wait_tick("t2a");
      check("t2_trunc", cnt_bcd, 8'h02);
      wait_tick("t2b");
      check("t2_one", cnt_bcd, 8'h01);
      wait_tick("t2c");
      check("t2_nsy", ns_light, 3'b010);
      wait_tick("t2d");
      wait_tick("t2e");
      check("t2_ar1_walk", walk, 1);
      check("t2_ar1_pend", ped_pend, 0);

      // Late request in EW green: no truncation.
      run_until(3, 2, "t3");
      cyc(1'b0, 1'b1, 1'b1);
      check("t3_pend_set", ped_pend, 1);
      wait_tick("t3a");
      check("t3_no_trunc", cnt_bcd, 8'h01);
      wait_tick("t3b");
      check("t3_ewy", ew_light, 3'b010);
      wait_tick("t3c");
      wait_tick("t3d");
      check("t3_ar2_pend", ped_pend, 0);

      // Freeze mid NS_Y, then resume from the held prescaler value.
      run_until(1, 2, "t4");
      cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
      check("t4_hold_cnt", cnt_bcd, 8'h02);
      check("t4_hold_ns", ns_light, 3'b010);
      n = 0;
      do begin
         cyc(1'b0, 1'b1, 1'b0);
         n++;
      end while (!tick && n < 10);
      check("t4_resume_gap", n, 3);

      // Reset mid EW_Y together with a pedestrian request.
      run_until(4, 2, "t5");
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      check("t5_cnt", cnt_bcd, 8'h06);
      check("t5_pend", ped_pend, 0);
      check("t5_tick", tick, 0);
      check("t5_ns", ns_light, 3'b001);
      check("t5_ew", ew_light, 3'b100);

      // Random en / ped_req with rare resets.
      for (int i = 0; i < 1000; i++) begin
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 19) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
